// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetches from instruction memory, decodes a small
// R-type ALU subset, times ALU execution (with a longer MUL), and retires via write-back.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        alu_en,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] pc,
  output logic [15:0] retire_cnt,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [31:0] HALT_WORD = 32'h0000_003F;
  localparam logic [5:0]  FUNCT_MUL = 6'b101010;
  localparam logic [3:0]  MUL_LOAD  = 4'(MUL_LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [15:0] retire_q;
  logic [3:0]  exec_cnt;
  logic        illegal_q;
  logic        is_halt;
  logic        is_legal;
  logic        is_mul;

  assign is_halt = (ir_q == HALT_WORD);
  assign is_mul  = (ir_q[5:0] == FUNCT_MUL);

  always_comb begin
    is_legal = 1'b0;
    if (ir_q[31:26] == 6'd0) begin
      case (ir_q[5:0])
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: is_legal = 1'b1;
        default: is_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  if (imem_ack) state_next = S_DECODE;
      S_DECODE: begin
        if (is_halt)       state_next = S_HALT;
        else if (is_legal) state_next = S_EXEC;
        else               state_next = S_FETCH;
      end
      S_EXEC:   if (exec_cnt == 4'd0) state_next = S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  // EXEC occupancy is exec_cnt+1 cycles, so the load value is latency minus one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      retire_q  <= 16'd0;
      exec_cnt  <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        S_FETCH: if (imem_ack) ir_q <= imem_rdata;
        S_DECODE: begin
          if (!is_halt && is_legal) begin
            exec_cnt <= is_mul ? MUL_LOAD : 4'd0;
          end else if (!is_halt) begin
            pc_q      <= pc_q + 32'd4;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: if (exec_cnt != 4'd0) exec_cnt <= exec_cnt - 4'd1;
        S_WB: begin
          pc_q <= pc_q + 32'd4;
          if (retire_q != 16'hFFFF) retire_q <= retire_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Fetch handshake: imem_req stays high with imem_addr=pc held until a cycle with
  // imem_ack=1; that edge captures imem_rdata and req drops the following cycle.
  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc_q;
  assign ir         = ir_q;
  assign alu_en     = (state == S_EXEC);
  assign rf_we      = (state == S_WB) && (ir_q[15:11] != 5'd0);
  assign rf_waddr   = ir_q[15:11];
  assign pc         = pc_q;
  assign retire_cnt = retire_q;
  assign illegal    = illegal_q;
  assign halted     = (state == S_HALT);

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- MUL_LATENCY, 4, EXEC cycles for MUL (legal range 1..15).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution from IDLE.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address (equals pc).
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction.
- ir  out  32  latched instruction, fed to the decoder.
- alu_en  out  1  ALU operands/result valid this cycle.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  5  write register, equals ir[15:11].
- pc  out  32  current program counter.
- retire_cnt  out  16  retired-instruction count.
- illegal  out  1  one-cycle pulse on an unsupported instruction.
- halted  out  1  sequencer stopped.

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-005 IDLE SHALL go to FETCH on the cycle after start=1; start SHALL be ignored in every other state.
REQ-006 In FETCH, the block SHALL assert imem_req and hold imem_addr=pc stable until imem_ack=1.
REQ-007 On the imem_ack edge, the block SHALL latch imem_rdata into ir, deassert imem_req in the next cycle and enter DECODE.
REQ-008 imem_ack SHALL be ignored outside FETCH.
REQ-009 DECODE SHALL last exactly one cycle and branch as follows:
- ir==32'h0000_003F: go to HALT.
- ir[31:26]==0 and ir[5:0] in {100000, 100010, 100100, 100101, 101010}: go to EXEC.
- anything else, including 32'h0000_0037: pulse illegal, set pc=pc+4, go to FETCH; no write, no retire.
REQ-010 EXEC SHALL assert alu_en every cycle it is occupied.
REQ-011 EXEC SHALL last 1 cycle, or MUL_LATENCY cycles when funct=101010, using a 4-bit down-counter loaded in DECODE.
REQ-012 EXEC SHALL go to WB when the counter reaches zero.
REQ-013 WB SHALL last one cycle with rf_we=1, except that rf_we SHALL stay 0 when ir[15:11]==0.
REQ-014 WB SHALL set pc=pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0), increment retire_cnt, then go to FETCH.
REQ-015 retire_cnt SHALL saturate at 16'hFFFF.
REQ-016 rf_waddr SHALL always equal ir[15:11].
REQ-017 alu_en and rf_we SHALL never be high in the same cycle.
REQ-018 HALT SHALL hold halted=1 and all strobes at 0, and SHALL be left only by reset.
REQ-019 The minimum latency for a non-MUL instruction with a 0-wait ack SHALL be 4 cycles: FETCH, DECODE, EXEC, WB.
REQ-020 All outputs SHALL be registered or decoded from the state register only; there SHALL be no combinational path from any input to any output.

Reset
REQ-021 While rst_n=0, the block SHALL hold: state=IDLE, pc=RESET_PC, ir=0, retire_cnt=0, imem_req=0, alu_en=0, rf_we=0, illegal=0, halted=0.
REQ-022 Reset asserted mid-FETCH or mid-EXEC SHALL drop imem_req, alu_en and rf_we immediately (asynchronously).
REQ-023 Reset mid-operation SHALL abandon the instruction in flight without a write or a retire.
REQ-024 After reset release, the block SHALL wait in IDLE for start.

Verification
REQ-025 Add: ir=32'h0022_1820 (rd=3), ack with 0 wait -> alu_en for 1 cycle, rf_we=1 with rf_waddr=3, pc 0->4, retire_cnt=1, total of 4 cycles.
REQ-026 Mul: funct=101010, MUL_LATENCY=4 -> alu_en high for exactly 4 cycles, then a single rf_we pulse.
REQ-027 Fetch stall: ack delayed 3 cycles -> imem_req and imem_addr stay stable for 4 cycles, and ir updates only on the ack edge.
REQ-028 Halt and illegal:
- 32'h0000_003F -> halted=1 permanently; further start pulses cause no fetch.
- opcode 6'b100011 -> one illegal pulse, pc+4, retire_cnt unchanged.
REQ-029 Boundaries:
- RESET_PC=32'hFFFF_FFFC, one add -> pc becomes 0.
- rd=0 -> no rf_we, yet retire_cnt increments.
- rst_n dropped during MUL EXEC -> outputs clear immediately, and no write occurs after release.
